// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register word offsets,
// edge-mode encodings and bus widths.
package gpio_pkg;

   localparam int GPIO_ADDR_W = 3;
   localparam int GPIO_DATA_W = 32;

   typedef enum logic [GPIO_ADDR_W-1:0] {
      GPIO_DATA_OUT   = 3'd0,
      GPIO_DIR        = 3'd1,
      GPIO_DATA_IN    = 3'd2,
      GPIO_SET        = 3'd3,
      GPIO_CLR        = 3'd4,
      GPIO_TGL        = 3'd5,
      GPIO_IRQ_EN     = 3'd6,
      GPIO_IRQ_STATUS = 3'd7
   } gpio_reg_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/gpio_if.sv
// IO-page bus seen by the GPIO controller: select, word offset, strobes and data.
interface gpio_if;
   import gpio_pkg::*;

   logic                   sel;
   logic [GPIO_ADDR_W-1:0] addr;
   logic                   write_en;
   logic [GPIO_DATA_W-1:0] wdata;
   logic                   read_en;
   logic [GPIO_DATA_W-1:0] rdata;

   modport master (output sel, addr, write_en, wdata, read_en, input rdata);
   modport slave  (input sel, addr, write_en, wdata, read_en, output rdata);

endinterface

// File: rtl/gpio_sync.sv
// Per-pin input synchroniser chain plus a "previous" flop feeding the edge detector.
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_BOTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;

   // Stage 0 takes the raw pins; the last stage is the synchronised value.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
         prev_q  <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], pins_i};
         prev_q  <= chain_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = chain_q[SYNC_STAGES-1];
   assign rise   = sync_o & ~prev_q;
   assign fall   = ~sync_o & prev_q;

   always_comb begin
      case (EDGE_MODE)
         EDGE_RISE: edge_o = rise;
         EDGE_FALL: edge_o = fall;
         default:   edge_o = rise | fall;
      endcase
   end

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction, atomic set/clear/toggle,
// synchronised inputs and sticky edge interrupts with write-1-to-clear status.
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_BOTH
) (
   input  logic             clk,
   input  logic             rst,
   gpio_if.slave            bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);

   logic [WIDTH-1:0]       dataOut_q, dataOut_d;
   logic [WIDTH-1:0]       dir_q, dir_d;
   logic [WIDTH-1:0]       irqEn_q, irqEn_d;
   logic [WIDTH-1:0]       irqStatus_q, irqStatus_d;
   logic [ARM_W-1:0]       armCnt_q, armCnt_d;
   logic [GPIO_DATA_W-1:0] rdata_q, rdata_d;
   logic                   irq_q, irq_d;

   logic [WIDTH-1:0] syncIn;
   logic [WIDTH-1:0] edgeRaw;
   logic [WIDTH-1:0] edgeArmed;
   logic [WIDTH-1:0] wdataW;
   logic [WIDTH-1:0] w1cMask;
   logic             armed;
   logic             wrStrobe;
   logic             rdStrobe;
   logic             unusedWdata;

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .pins_i (gpio_in),
      .sync_o (syncIn),
      .edge_o (edgeRaw)
   );

   assign wrStrobe    = bus.sel && bus.write_en;
   assign rdStrobe    = bus.sel && bus.read_en;
   assign wdataW      = bus.wdata[WIDTH-1:0];
   assign unusedWdata = ^bus.wdata;

   // Edges are ignored until the synchroniser chain has filled after reset.
   assign armed     = (armCnt_q == ARM_W'(ARM_MAX));
   assign edgeArmed = armed ? edgeRaw : '0;

   always_comb begin
      dataOut_d = dataOut_q;
      dir_d     = dir_q;
      irqEn_d   = irqEn_q;
      w1cMask   = '0;
      if (wrStrobe) begin
         case (gpio_reg_e'(bus.addr))
            GPIO_DATA_OUT:   dataOut_d = wdataW;
            GPIO_DIR:        dir_d     = wdataW;
            GPIO_SET:        dataOut_d = dataOut_q | wdataW;
            GPIO_CLR:        dataOut_d = dataOut_q & ~wdataW;
            GPIO_TGL:        dataOut_d = dataOut_q ^ wdataW;
            GPIO_IRQ_EN:     irqEn_d   = wdataW;
            GPIO_IRQ_STATUS: w1cMask   = wdataW;
            default:         ;
         endcase
      end
      // A fresh edge beats a simultaneous write-1-to-clear on the same bit.
      irqStatus_d = (irqStatus_q & ~w1cMask) | edgeArmed;
      armCnt_d    = armed ? armCnt_q : armCnt_q + ARM_W'(1);
      irq_d       = |(irqStatus_q & irqEn_q);
   end

   // Reads sample the pre-write register values, so read-during-write returns old data.
   always_comb begin
      rdata_d = rdata_q;
      if (rdStrobe) begin
         case (gpio_reg_e'(bus.addr))
            GPIO_DATA_OUT:   rdata_d = GPIO_DATA_W'(dataOut_q);
            GPIO_DIR:        rdata_d = GPIO_DATA_W'(dir_q);
            GPIO_DATA_IN:    rdata_d = GPIO_DATA_W'(syncIn);
            GPIO_IRQ_EN:     rdata_d = GPIO_DATA_W'(irqEn_q);
            GPIO_IRQ_STATUS: rdata_d = GPIO_DATA_W'(irqStatus_q);
            default:         rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataOut_q   <= '0;
         dir_q       <= '0;
         irqEn_q     <= '0;
         irqStatus_q <= '0;
         armCnt_q    <= '0;
         rdata_q     <= '0;
         irq_q       <= 1'b0;
      end else begin
         dataOut_q   <= dataOut_d;
         dir_q       <= dir_d;
         irqEn_q     <= irqEn_d;
         irqStatus_q <= irqStatus_d;
         armCnt_q    <= armCnt_d;
         rdata_q     <= rdata_d;
         irq_q       <= irq_d;
      end
   end

   assign gpio_out  = dataOut_q;
   assign gpio_oe   = dir_q;
   assign irq       = irq_q;
   assign bus.rdata = rdata_q;

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller for the RISC-V SoC IO page. It replaces the single write-only output register with per-pin direction control, a synchronised input path, atomic set/clear/toggle writes, and edge-triggered interrupts with a sticky, write-1-to-clear status register. It sits behind the SoC IO decode: the SoC asserts `sel` for the GPIO word range and drives `addr` from the low word-address bits.

## Interface
Parameters:
- `WIDTH`, default 8: number of GPIO pins, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, minimum 2.
- `EDGE_MODE`, default 2: interrupt edge type; 0 = rising, 1 = falling, 2 = both.

Ports:
- `clk` in 1: system clock. The block has one clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `sel` in 1: block selected (IO page access to the GPIO range).
- `addr` in 3: register word offset.
- `write_en` in 1: write strobe (OR of the byte mask). Every write is treated as a full-word write.
- `wdata` in 32: write data.
- `read_en` in 1: read strobe.
- `rdata` out 32: registered read data.
- `gpio_in` in WIDTH: asynchronous pin inputs.
- `gpio_out` out WIDTH: output data register.
- `gpio_oe` out WIDTH: output enable, equal to DIR (1 = drive the pin).
- `irq` out 1: level interrupt, registered.

## Operation
- Register map (word offset, access, meaning):
  - 0 DATA_OUT, RW.
  - 1 DIR, RW; 1 = output.
  - 2 DATA_IN, RO; synchronised pin values.
  - 3 SET, WO; DATA_OUT |= wdata.
  - 4 CLR, WO; DATA_OUT &= ~wdata.
  - 5 TGL, WO; DATA_OUT ^= wdata.
  - 6 IRQ_EN, RW.
  - 7 IRQ_STATUS, R/W1C.
- A write takes effect only when `sel && write_en`.
- A read is captured only when `sel && read_en`.
- Write-only offsets (3, 4, 5) read as 0.
- Only `wdata[WIDTH-1:0]` is used. Reads zero-extend to 32 bits.
- Input path: a `SYNC_STAGES`-deep flop chain per pin, then one "previous" flop per pin.
  - rise = sync & ~prev
  - fall = ~sync & prev
  - The edge term is selected by `EDGE_MODE`.
- Edge detection runs on every pin regardless of DIR, so an output pin can loop back through `gpio_in` for self-test.
- IRQ_STATUS bits set on a detected edge whether or not IRQ_EN is set. They clear only by writing 1 to offset 7.
- When a W1C write and a new edge hit the same bit in the same cycle, set wins.
- `irq` is registered: irq <= |(IRQ_STATUS & IRQ_EN).
- Arm counter: after reset, edge detection is masked for `SYNC_STAGES+1` cycles. This stops an input that is already high from raising a spurious rising edge while the chain fills. The counter saturates and then holds the armed state.
- Reset values: DATA_OUT=0, DIR=0 (all pins inputs), IRQ_EN=0, IRQ_STATUS=0, sync and prev flops 0, arm counter 0, `rdata`=0, `irq`=0.
- Reset asserted mid-operation clears all of the above on the next edge. Any write or read in that cycle is discarded.

## Timing
- Write latency: a register write is visible on `gpio_out`/`gpio_oe` one edge after the strobe cycle. SET, CLR and TGL have the same latency.
- Read latency: `rdata` is loaded on the edge where `sel && read_en`. It holds until the next qualified read, which matches RAM timing in the processor's LOAD/WAIT_DATA sequence.
- A read and a write to the same register in the same cycle return the old value.
- Input latency, counting from the first edge that samples a changed pin:
  - DATA_IN shows the change after `SYNC_STAGES` edges.
  - The IRQ_STATUS bit sets on the next edge.
  - `irq` rises one edge after that, provided IRQ_EN is set.
- Enabling IRQ_EN while a status bit is already set asserts `irq` one edge after the write.
- Pulses shorter than one `clk` period may be missed; this is not a defect.

## Structure
- Package `gpio_pkg` holds:
  - register offset constants `GPIO_DATA_OUT` … `GPIO_IRQ_STATUS`;
  - `EDGE_MODE` encodings `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`.
- Sub-module `gpio_sync`, parametrised by `WIDTH`, `SYNC_STAGES` and `EDGE_MODE`, contains the synchroniser chain, the prev flop and the edge outputs.
- The top level contains:
  - the register file;
  - write decode;
  - the arm counter;
  - the W1C/set priority logic;
  - the registered read mux.

## Test plan
- Reset: hold `rst` 2 cycles with `gpio_in`=8'hFF. Required: all outputs 0; no IRQ_STATUS bits set after the arm window; a DATA_IN read returns 32'h000000FF.
- Atomic ops: write DATA_OUT=8'hA5, SET 8'h0F, CLR 8'h81, TGL 8'hFF. Required: `gpio_out` steps through A5, AF, 2E, D1, each one cycle after its write.
- Edge IRQ (EDGE_MODE=0): IRQ_EN=8'h04; drive pin 2 from 0 to 1. Required: IRQ_STATUS=8'h04 at edge SYNC_STAGES+1; `irq`=1 one edge later. Then W1C 8'h04. Required: `irq`=0 two edges after the write.
- Disabled pin: toggle pin 5 with IRQ_EN=0. Required: IRQ_STATUS bit 5 sets and `irq` stays 0. Then write IRQ_EN=8'h20. Required: `irq`=1 one edge after the write.
- Collision: issue a W1C to bit 3 in the same cycle a falling edge on pin 3 reaches detection (EDGE_MODE=2). Required: the bit remains 1.
- Width and offset: with WIDTH=32, write 32'hFFFF_FFFF to DIR and read it back. Required: 32'hFFFF_FFFF. A read of offset 3 returns 0. A `sel`=0 write leaves all registers unchanged.
